qpu_exu_oitf: RTL and testbench

Outstanding Instruction Track FIFO for the QPU execute unit. It is the responder on the dispatch↔OITF interface:

- It accepts `disp_oitf_ena` and `disp_moitf_ena` allocations from `QPU_exu_disp`.
- It returns hazard matches for the instruction currently being dispatched: `oitfrd_match_disprs1/rs2/rd` and `oitfqf_match_dispql`.
- It frees entries when long-pipe writebacks and measurement results retire.

It holds two in-order queues: the OITF (classical destination registers) and the MOITF (qubit lists of in-flight measure instructions).

---
 rtl/qpu_exu_oitf_pkg.sv | 9 +
 rtl/qpu_exu_oitf_ptr.sv | 61 ++++++
 rtl/qpu_exu_oitf.sv | 114 +++++++++++
 tb/tb_qpu_exu_oitf.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/qpu_exu_oitf_pkg.sv
// Shared widths and default queue depths for the QPU outstanding-instruction tracker.
package qpu_exu_oitf_pkg;

  localparam int QPU_RFIDX_REAL_WIDTH = 5;
  localparam int QPU_QUBIT_NUM        = 8;
  localparam int QPU_OITF_DEPTH       = 4;
  localparam int QPU_MOITF_DEPTH      = 4;

endpackage

// File: rtl/qpu_exu_oitf_ptr.sv
// Circular-buffer bookkeeping for one tracking queue: wrap-bit pointers,
// per-entry valid bits and the full/empty/ready flags.
module qpu_exu_oitf_ptr #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  output logic [AW-1:0]    wr_idx,
  output logic [AW-1:0]    rd_idx,
  output logic [DEPTH-1:0] valid,
  output logic             empty,
  output logic             ready,
  output logic             push_fire
);

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [DEPTH-1:0] valid_reg;
  logic             full;
  logic             pop_fire;

  assign wr_idx = wr_ptr_reg[AW-1:0];
  assign rd_idx = rd_ptr_reg[AW-1:0];
  assign full   = (wr_idx == rd_idx) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign ready  = !full;
  assign valid  = valid_reg;

  // Ready ignores a same-cycle pop, so a full queue never accepts a push.
  assign push_fire = push && !full;
  assign pop_fire  = pop && !empty;

  // DEPTH is a power of two, so plain increment wraps the index and toggles the wrap bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_fire) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop_fire)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg[gi] <= 1'b0;
        end else if (push_fire && (wr_idx == AW'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end else if (pop_fire && (rd_idx == AW'(gi))) begin
          valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/qpu_exu_oitf.sv
// Outstanding instruction tracker: in-order rd queue (OITF) and measure qubit-list
// queue (MOITF), with combinational hazard matching against the dispatching instruction.
module qpu_exu_oitf
  import qpu_exu_oitf_pkg::*;
#(
  parameter int OITF_DEPTH  = QPU_OITF_DEPTH,
  parameter int MOITF_DEPTH = QPU_MOITF_DEPTH,
  parameter int RFIDX_W     = QPU_RFIDX_REAL_WIDTH,
  parameter int QUBIT_NUM   = QPU_QUBIT_NUM
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 disp_oitf_ena,
  output logic                 disp_oitf_ready,
  input  logic                 disp_oitf_rs1en,
  input  logic                 disp_oitf_rs2en,
  input  logic                 disp_oitf_rdwen,
  input  logic [RFIDX_W-1:0]   disp_oitf_rs1idx,
  input  logic [RFIDX_W-1:0]   disp_oitf_rs2idx,
  input  logic [RFIDX_W-1:0]   disp_oitf_rdidx,
  output logic                 oitfrd_match_disprs1,
  output logic                 oitfrd_match_disprs2,
  output logic                 oitfrd_match_disprd,
  input  logic                 disp_moitf_ena,
  output logic                 disp_moitf_ready,
  input  logic                 disp_oitf_qfren,
  input  logic [QUBIT_NUM-1:0] disp_oitf_qubitlist,
  output logic                 oitfqf_match_dispql,
  input  logic                 oitf_ret_ena,
  output logic [RFIDX_W-1:0]   oitf_ret_rdidx,
  output logic                 oitf_ret_rdwen,
  input  logic                 moitf_ret_ena,
  output logic [QUBIT_NUM-1:0] moitf_ret_qubitlist,
  output logic                 oitf_empty,
  output logic                 moitf_empty
);

  localparam int OAW = $clog2(OITF_DEPTH);
  localparam int MAW = $clog2(MOITF_DEPTH);

  logic [OAW-1:0]         o_wr_idx, o_rd_idx;
  logic [OITF_DEPTH-1:0]  o_valid;
  logic                   o_push;
  logic [MAW-1:0]         m_wr_idx, m_rd_idx;
  logic [MOITF_DEPTH-1:0] m_valid;
  logic                   m_push;

  qpu_exu_oitf_ptr #(.DEPTH(OITF_DEPTH)) u_oitf_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (disp_oitf_ena),
    .pop       (oitf_ret_ena),
    .wr_idx    (o_wr_idx),
    .rd_idx    (o_rd_idx),
    .valid     (o_valid),
    .empty     (oitf_empty),
    .ready     (disp_oitf_ready),
    .push_fire (o_push)
  );

  qpu_exu_oitf_ptr #(.DEPTH(MOITF_DEPTH)) u_moitf_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (disp_moitf_ena),
    .pop       (moitf_ret_ena),
    .wr_idx    (m_wr_idx),
    .rd_idx    (m_rd_idx),
    .valid     (m_valid),
    .empty     (moitf_empty),
    .ready     (disp_moitf_ready),
    .push_fire (m_push)
  );

  // Payload needs no reset: every consumer is gated by a valid bit or the empty flag.
  logic [RFIDX_W-1:0]   oitf_rdidx_reg [OITF_DEPTH];
  logic [OITF_DEPTH-1:0] oitf_rdwen_reg;
  logic [QUBIT_NUM-1:0] moitf_ql_reg   [MOITF_DEPTH];

  always_ff @(posedge clk) begin
    if (o_push) begin
      oitf_rdidx_reg[o_wr_idx] <= disp_oitf_rdidx;
      oitf_rdwen_reg[o_wr_idx] <= disp_oitf_rdwen;
    end
    if (m_push) begin
      moitf_ql_reg[m_wr_idx] <= disp_oitf_qubitlist;
    end
  end

  logic [OITF_DEPTH-1:0]  hit_rs1, hit_rs2, hit_rd;
  logic [MOITF_DEPTH-1:0] hit_ql;

  generate
    for (genvar gi = 0; gi < OITF_DEPTH; gi++) begin : g_oitf_match
      logic live;
      assign live        = o_valid[gi] && oitf_rdwen_reg[gi];
      assign hit_rs1[gi] = live && (oitf_rdidx_reg[gi] == disp_oitf_rs1idx);
      assign hit_rs2[gi] = live && (oitf_rdidx_reg[gi] == disp_oitf_rs2idx);
      assign hit_rd[gi]  = live && (oitf_rdidx_reg[gi] == disp_oitf_rdidx);
    end
    for (genvar gi = 0; gi < MOITF_DEPTH; gi++) begin : g_moitf_match
      assign hit_ql[gi] = m_valid[gi] && (|(moitf_ql_reg[gi] & disp_oitf_qubitlist));
    end
  endgenerate

  assign oitfrd_match_disprs1 = disp_oitf_rs1en && (|hit_rs1);
  assign oitfrd_match_disprs2 = disp_oitf_rs2en && (|hit_rs2);
  assign oitfrd_match_disprd  = disp_oitf_rdwen && (|hit_rd);
  assign oitfqf_match_dispql  = disp_oitf_qfren && (|hit_ql);

  assign oitf_ret_rdidx      = oitf_empty  ? '0   : oitf_rdidx_reg[o_rd_idx];
  assign oitf_ret_rdwen      = oitf_empty  ? 1'b0 : oitf_rdwen_reg[o_rd_idx];
  assign moitf_ret_qubitlist = moitf_empty ? '0   : moitf_ql_reg[m_rd_idx];

endmodule

// File: tb/tb_qpu_exu_oitf.sv
// Directed bench for qpu_exu_oitf: a vector table plus hand-written multi-cycle sequences.
module tb_qpu_exu_oitf;

  localparam int RW = 5;
  localparam int QN = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          disp_oitf_ena, disp_oitf_ready;
  logic          disp_oitf_rs1en, disp_oitf_rs2en, disp_oitf_rdwen;
  logic [RW-1:0] disp_oitf_rs1idx, disp_oitf_rs2idx, disp_oitf_rdidx;
  logic          oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd;
  logic          disp_moitf_ena, disp_moitf_ready;
  logic          disp_oitf_qfren;
  logic [QN-1:0] disp_oitf_qubitlist;
  logic          oitfqf_match_dispql;
  logic          oitf_ret_ena;
  logic [RW-1:0] oitf_ret_rdidx;
  logic          oitf_ret_rdwen;
  logic          moitf_ret_ena;
  logic [QN-1:0] moitf_ret_qubitlist;
  logic          oitf_empty, moitf_empty;

  always #5 clk = ~clk;

  qpu_exu_oitf dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .disp_oitf_ena        (disp_oitf_ena),
    .disp_oitf_ready      (disp_oitf_ready),
    .disp_oitf_rs1en      (disp_oitf_rs1en),
    .disp_oitf_rs2en      (disp_oitf_rs2en),
    .disp_oitf_rdwen      (disp_oitf_rdwen),
    .disp_oitf_rs1idx     (disp_oitf_rs1idx),
    .disp_oitf_rs2idx     (disp_oitf_rs2idx),
    .disp_oitf_rdidx      (disp_oitf_rdidx),
    .oitfrd_match_disprs1 (oitfrd_match_disprs1),
    .oitfrd_match_disprs2 (oitfrd_match_disprs2),
    .oitfrd_match_disprd  (oitfrd_match_disprd),
    .disp_moitf_ena       (disp_moitf_ena),
    .disp_moitf_ready     (disp_moitf_ready),
    .disp_oitf_qfren      (disp_oitf_qfren),
    .disp_oitf_qubitlist  (disp_oitf_qubitlist),
    .oitfqf_match_dispql  (oitfqf_match_dispql),
    .oitf_ret_ena         (oitf_ret_ena),
    .oitf_ret_rdidx       (oitf_ret_rdidx),
    .oitf_ret_rdwen       (oitf_ret_rdwen),
    .moitf_ret_ena        (moitf_ret_ena),
    .moitf_ret_qubitlist  (moitf_ret_qubitlist),
    .oitf_empty           (oitf_empty),
    .moitf_empty          (moitf_empty)
  );

  typedef struct {
    logic oena; logic rdwen; logic [RW-1:0] rdidx;
    logic rs1en; logic [RW-1:0] rs1idx;
    logic rs2en; logic [RW-1:0] rs2idx;
    logic oret; logic mena; logic qfren; logic [QN-1:0] ql; logic mret;
    logic [21:0] exp;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t v(input logic oena, rdwen, input logic [RW-1:0] rdidx,
                             input logic rs1en, input logic [RW-1:0] rs1idx,
                             input logic rs2en, input logic [RW-1:0] rs2idx,
                             input logic oret, mena, qfren, input logic [QN-1:0] ql,
                             input logic mret);
    vec_t r;
    r.oena = oena; r.rdwen = rdwen; r.rdidx = rdidx;
    r.rs1en = rs1en; r.rs1idx = rs1idx; r.rs2en = rs2en; r.rs2idx = rs2idx;
    r.oret = oret; r.mena = mena; r.qfren = qfren; r.ql = ql; r.mret = mret;
    r.exp = '0;
    return r;
  endfunction

  // Packs {m1,m2,md,mq,oready,oempty,ret_rdwen,ret_rdidx,mready,mempty,ret_ql}.
  function automatic logic [21:0] ex(input logic m1, m2, md, mq, ordy, oemp, rwen,
                                     input logic [RW-1:0] ridx, input logic mrdy, memp,
                                     input logic [QN-1:0] rql);
    return {m1, m2, md, mq, ordy, oemp, rwen, ridx, mrdy, memp, rql};
  endfunction

  task automatic idle();
    disp_oitf_ena = 0; disp_oitf_rdwen = 0; disp_oitf_rdidx = '0;
    disp_oitf_rs1en = 0; disp_oitf_rs1idx = '0; disp_oitf_rs2en = 0; disp_oitf_rs2idx = '0;
    oitf_ret_ena = 0; disp_moitf_ena = 0; disp_oitf_qfren = 0; disp_oitf_qubitlist = '0;
    moitf_ret_ena = 0;
  endtask

  task automatic push_o(input logic [RW-1:0] rd);
    @(negedge clk); idle(); disp_oitf_ena = 1; disp_oitf_rdwen = 1; disp_oitf_rdidx = rd;
    @(posedge clk); #1 idle();
  endtask

  task automatic pop_o(input logic [RW-1:0] exp_rd, input string nm);
    @(negedge clk); idle(); oitf_ret_ena = 1; #1;
    chk(nm, 32'(oitf_ret_rdidx), 32'(exp_rd));
    @(posedge clk); #1 idle();
  endtask

  vec_t vecs[13];
  int   q[$];

  initial begin
    idle();
    rst_n = 0;
    #2;
    chk("reset_oitf_ready", 32'(disp_oitf_ready), 1);
    chk("reset_moitf_ready", 32'(disp_moitf_ready), 1);
    chk("reset_empties", 32'({oitf_empty, moitf_empty}), 3);
    chk("reset_ret", 32'({oitf_ret_rdwen, oitf_ret_rdidx, moitf_ret_qubitlist}), 0);
    @(negedge clk); rst_n = 1;

    vecs[0]  = v(0,0,0, 0,0, 0,0, 0,0,0,8'h00,0); vecs[0].exp  = ex(0,0,0,0,1,1,0,0,1,1,8'h00);
    vecs[1]  = v(1,1,5, 1,5, 0,0, 0,0,0,8'h00,0); vecs[1].exp  = ex(0,0,0,0,1,1,0,0,1,1,8'h00);
    vecs[2]  = v(0,0,0, 1,5, 1,3, 0,0,0,8'h00,0); vecs[2].exp  = ex(1,0,0,0,1,0,1,5,1,1,8'h00);
    vecs[3]  = v(0,1,5, 0,5, 1,5, 0,0,0,8'h00,0); vecs[3].exp  = ex(0,1,1,0,1,0,1,5,1,1,8'h00);
    vecs[4]  = v(1,0,7, 1,7, 0,0, 0,0,0,8'h00,0); vecs[4].exp  = ex(0,0,0,0,1,0,1,5,1,1,8'h00);
    vecs[5]  = v(0,0,0, 1,7, 1,5, 1,0,0,8'h00,0); vecs[5].exp  = ex(0,1,0,0,1,0,1,5,1,1,8'h00);
    vecs[6]  = v(0,0,0, 0,0, 1,5, 1,0,0,8'h00,0); vecs[6].exp  = ex(0,0,0,0,1,0,0,7,1,1,8'h00);
    vecs[7]  = v(0,0,0, 0,0, 0,0, 1,0,0,8'h00,0); vecs[7].exp  = ex(0,0,0,0,1,1,0,0,1,1,8'h00);
    vecs[8]  = v(0,0,0, 0,0, 0,0, 0,1,1,8'h02,0); vecs[8].exp  = ex(0,0,0,0,1,1,0,0,1,1,8'h00);
    vecs[9]  = v(0,0,0, 0,0, 0,0, 0,0,1,8'h03,0); vecs[9].exp  = ex(0,0,0,1,1,1,0,0,1,0,8'h02);
    vecs[10] = v(0,0,0, 0,0, 0,0, 0,0,1,8'h04,0); vecs[10].exp = ex(0,0,0,0,1,1,0,0,1,0,8'h02);
    vecs[11] = v(0,0,0, 0,0, 0,0, 0,0,0,8'h03,1); vecs[11].exp = ex(0,0,0,0,1,1,0,0,1,0,8'h02);
    vecs[12] = v(0,0,0, 0,0, 0,0, 0,0,1,8'hFF,0); vecs[12].exp = ex(0,0,0,0,1,1,0,0,1,1,8'h00);

    for (int i = 0; i < 13; i++) begin
      logic [21:0] act;
      @(negedge clk);
      disp_oitf_ena = vecs[i].oena; disp_oitf_rdwen = vecs[i].rdwen; disp_oitf_rdidx = vecs[i].rdidx;
      disp_oitf_rs1en = vecs[i].rs1en; disp_oitf_rs1idx = vecs[i].rs1idx;
      disp_oitf_rs2en = vecs[i].rs2en; disp_oitf_rs2idx = vecs[i].rs2idx;
      oitf_ret_ena = vecs[i].oret; disp_moitf_ena = vecs[i].mena;
      disp_oitf_qfren = vecs[i].qfren; disp_oitf_qubitlist = vecs[i].ql; moitf_ret_ena = vecs[i].mret;
      #1;
      act = ex(oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd, oitfqf_match_dispql,
               disp_oitf_ready, oitf_empty, oitf_ret_rdwen, oitf_ret_rdidx,
               disp_moitf_ready, moitf_empty, moitf_ret_qubitlist);
      $display("vec %0d: outputs %06h expected %06h", i, act, vecs[i].exp);
      chk($sformatf("vec%0d", i), 32'(act), 32'(vecs[i].exp));
    end
    @(negedge clk); idle();

    // Fill, refused push during pop, then FIFO order across the pointer wrap.
    push_o(1); push_o(2); push_o(3);
    chk("ready_at_3", 32'(disp_oitf_ready), 1);
    push_o(4);
    chk("ready_at_full", 32'(disp_oitf_ready), 0);
    @(negedge clk); idle(); disp_oitf_ena = 1; disp_oitf_rdwen = 1; disp_oitf_rdidx = 9; oitf_ret_ena = 1;
    @(posedge clk); #1 idle();
    chk("ready_after_pop", 32'(disp_oitf_ready), 1);
    chk("head_after_pop", 32'(oitf_ret_rdidx), 2);
    disp_oitf_rs1en = 1; disp_oitf_rs1idx = 9; #1;
    chk("refused_push_absent", 32'(oitfrd_match_disprs1), 0);
    $display("seq full: refused push checked");
    pop_o(2, "pop_2");
    push_o(12); push_o(13);
    chk("ready_full_wrapped", 32'(disp_oitf_ready), 0);
    pop_o(3, "wrap_head_3"); pop_o(4, "wrap_head_4");
    pop_o(12, "wrap_head_12"); pop_o(13, "wrap_head_13");
    chk("empty_after_drain", 32'(oitf_empty), 1);

    // Occupancy 2 with simultaneous push and pop.
    push_o(20); push_o(21);
    q = '{20, 21};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); idle();
      disp_oitf_ena = 1; disp_oitf_rdwen = 1; disp_oitf_rdidx = RW'(22 + k); oitf_ret_ena = 1;
      #1;
      $display("seq pushpop %0d: head %0d expected %0d", k, oitf_ret_rdidx, q[0]);
      chk($sformatf("pushpop_head%0d", k), 32'(oitf_ret_rdidx), 32'(q[0]));
      @(posedge clk); #1 idle();
      void'(q.pop_front()); q.push_back(22 + k);
      chk($sformatf("pushpop_flags%0d", k), 32'({oitf_empty, disp_oitf_ready}), 32'b01);
    end
    pop_o(26, "pushpop_tail_26"); pop_o(27, "pushpop_tail_27");
    chk("pushpop_empty", 32'(oitf_empty), 1);

    // Pop while empty is ignored; a later push must land at the head.
    @(negedge clk); idle(); oitf_ret_ena = 1;
    @(posedge clk); #1 idle();
    chk("empty_pop_flag", 32'(oitf_empty), 1);
    chk("empty_pop_ret", 32'(oitf_ret_rdidx), 0);
    push_o(30);
    chk("after_empty_pop_head", 32'(oitf_ret_rdidx), 30);
    pop_o(30, "after_empty_pop_pop");

    // Asynchronous reset with entries outstanding.
    push_o(1); push_o(2); push_o(3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); idle(); disp_moitf_ena = 1; disp_oitf_qubitlist = QN'(1 << k);
      @(posedge clk); #1 idle();
    end
    chk("moitf_full_ready", 32'(disp_moitf_ready), 0);
    @(negedge clk); idle(); disp_oitf_rs1en = 1; disp_oitf_rs1idx = 2;
    disp_oitf_qfren = 1; disp_oitf_qubitlist = 8'h08; #1;
    chk("pre_reset_match", 32'({oitfrd_match_disprs1, oitfqf_match_dispql}), 3);
    rst_n = 0; #1;
    chk("async_reset_empty", 32'({oitf_empty, moitf_empty}), 3);
    chk("async_reset_ready", 32'({disp_oitf_ready, disp_moitf_ready}), 3);
    chk("async_reset_match", 32'({oitfrd_match_disprs1, oitfqf_match_dispql}), 0);
    chk("async_reset_ret", 32'({oitf_ret_rdwen, oitf_ret_rdidx, moitf_ret_qubitlist}), 0);
    $display("seq reset: checked before next edge");
    @(negedge clk); idle(); rst_n = 1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
